// File: rtl/reg_file_rename.sv
// Architectural register file with rename status.
// Holds 32 committed values plus, per register, a busy bit and the ROB tag
// of the youngest in-flight producer. Operand reads are combinational and
// bypass a matching commit in the same cycle. x0 is hardwired to zero.
module reg_file_rename #(
  parameter int DATA_W    = 32,
  parameter int REG_W     = 5,
  parameter int ROB_TAG_W = 4
) (
  input  logic                 in_clk,
  input  logic                 in_rst_n,
  input  logic                 in_rdy,
  input  logic                 in_flush_enable,
  input  logic [REG_W-1:0]     in_decoder_rs,
  input  logic [REG_W-1:0]     in_decoder_rt,
  output logic                 out_decoder_rs_busy,
  output logic                 out_decoder_rt_busy,
  output logic [ROB_TAG_W-1:0] out_decoder_rs_reorder,
  output logic [ROB_TAG_W-1:0] out_decoder_rt_reorder,
  output logic [DATA_W-1:0]    out_decoder_rs_value,
  output logic [DATA_W-1:0]    out_decoder_rt_value,
  input  logic                 in_decoder_rename_enable,
  input  logic [REG_W-1:0]     in_decoder_rd,
  input  logic [ROB_TAG_W-1:0] in_decoder_reorder,
  input  logic                 in_rob_commit_enable,
  input  logic [REG_W-1:0]     in_rob_commit_rd,
  input  logic [DATA_W-1:0]    in_rob_commit_value,
  input  logic [ROB_TAG_W-1:0] in_rob_commit_reorder
);

  localparam int NREG = 1 << REG_W;

  logic [DATA_W-1:0]    value_reg [NREG];
  logic                 busy_reg  [NREG];
  logic [ROB_TAG_W-1:0] tag_reg   [NREG];

  // A rename presented together with a flush belongs to the squashed path.
  logic rename_ok;
  logic commit_ok;
  assign rename_ok = in_rdy && in_decoder_rename_enable && !in_flush_enable;
  assign commit_ok = in_rdy && in_rob_commit_enable;

  genvar gi;
  generate
    for (gi = 0; gi < NREG; gi++) begin : g_reg
      // x0 never matches a hit, so its state stays at the reset value of zero.
      logic commit_hit;
      logic rename_hit;
      assign commit_hit = (gi != 0) && commit_ok && (in_rob_commit_rd == REG_W'(gi));
      assign rename_hit = (gi != 0) && rename_ok && (in_decoder_rd == REG_W'(gi));

      // Committed value: commits are in program order, so always overwrite.
      always_ff @(posedge in_clk or negedge in_rst_n) begin
        if (!in_rst_n) begin
          value_reg[gi] <= '0;
        end else if (commit_hit) begin
          value_reg[gi] <= in_rob_commit_value;
        end
      end

      // Rename status: rename beats flush/commit; a stale commit leaves it.
      always_ff @(posedge in_clk or negedge in_rst_n) begin
        if (!in_rst_n) begin
          busy_reg[gi] <= 1'b0;
          tag_reg[gi]  <= '0;
        end else if (rename_hit) begin
          busy_reg[gi] <= 1'b1;
          tag_reg[gi]  <= in_decoder_reorder;
        end else if (in_rdy && in_flush_enable) begin
          busy_reg[gi] <= 1'b0;
        end else if (commit_hit && (tag_reg[gi] == in_rob_commit_reorder)) begin
          busy_reg[gi] <= 1'b0;
        end
      end
    end
  endgenerate

  // rs read port with same-cycle commit bypass (independent of rdy/flush).
  always_comb begin
    out_decoder_rs_busy    = busy_reg[in_decoder_rs];
    out_decoder_rs_reorder = tag_reg[in_decoder_rs];
    out_decoder_rs_value   = value_reg[in_decoder_rs];
    if (in_rob_commit_enable && (in_rob_commit_rd == in_decoder_rs) &&
        (in_decoder_rs != '0) && busy_reg[in_decoder_rs] &&
        (tag_reg[in_decoder_rs] == in_rob_commit_reorder)) begin
      out_decoder_rs_busy  = 1'b0;
      out_decoder_rs_value = in_rob_commit_value;
    end
  end

  // rt read port with same-cycle commit bypass (independent of rdy/flush).
  always_comb begin
    out_decoder_rt_busy    = busy_reg[in_decoder_rt];
    out_decoder_rt_reorder = tag_reg[in_decoder_rt];
    out_decoder_rt_value   = value_reg[in_decoder_rt];
    if (in_rob_commit_enable && (in_rob_commit_rd == in_decoder_rt) &&
        (in_decoder_rt != '0) && busy_reg[in_decoder_rt] &&
        (tag_reg[in_decoder_rt] == in_rob_commit_reorder)) begin
      out_decoder_rt_busy  = 1'b0;
      out_decoder_rt_value = in_rob_commit_value;
    end
  end

endmodule
